// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the two-requester RAM arbiter: FSM states and owner ids.
package ram_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_HOLD  = 3'd3,
    ST_RD_DONE  = 3'd4
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select between requesters A and B.
// RAM_ARB_ROUND_ROBIN_EN: ties follow the pointer; otherwise A always wins ties.
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
`ifdef RAM_ARB_ROUND_ROBIN_EN
  input  logic ptr,
`endif
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = a_req | b_req;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  assign grant_id = (a_req & b_req) ? ptr : (b_req ? OWN_B : OWN_A);
`else
  assign grant_id = a_req ? OWN_A : OWN_B;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between requesters A and B.
// RAM_ARB_ROUND_ROBIN_EN selects alternating service under contention.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int addressWidth = 8,
  parameter int dataWidth    = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_req,
  input  logic                    a_write,
  input  logic [addressWidth-1:0] a_address,
  input  logic [dataWidth-1:0]    a_wdata,
  output logic                    a_done,
  output logic [dataWidth-1:0]    a_rdata,
  input  logic                    b_req,
  input  logic                    b_write,
  input  logic [addressWidth-1:0] b_address,
  input  logic [dataWidth-1:0]    b_wdata,
  output logic                    b_done,
  output logic [dataWidth-1:0]    b_rdata,
  output logic                    ram_select,
  output logic                    ram_write,
  output logic                    ram_out,
  output logic [addressWidth-1:0] ram_address,
  inout  wire  [dataWidth-1:0]    ram_data
);

  typedef struct packed {
    logic                    write;
    logic [addressWidth-1:0] addr;
    logic [dataWidth-1:0]    wdata;
  } op_t;

  state_t state, state_nxt;
  op_t    op, sel_op;
  logic   owner, grant_valid, grant_id;
  logic   drive, done_any;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic ptr;

  always_ff @(posedge clock) begin
    if (reset) ptr <= OWN_A;
    else if (state == ST_IDLE && grant_valid) ptr <= ~grant_id;
  end
`endif

  ram_arb_pick u_pick (
    .a_req       (a_req),
    .b_req       (b_req),
`ifdef RAM_ARB_ROUND_ROBIN_EN
    .ptr         (ptr),
`endif
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_op = (grant_id == OWN_B) ? {b_write, b_address, b_wdata}
                                      : {a_write, a_address, a_wdata};

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      op      <= '0;
      owner   <= OWN_A;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && grant_valid) begin
        op    <= sel_op;
        owner <= grant_id;
      end
      // RAM output register is stable on the bus throughout RD_HOLD
      if (state == ST_RD_HOLD) begin
        if (owner == OWN_A) a_rdata <= ram_data;
        else                b_rdata <= ram_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (grant_valid) state_nxt = sel_op.write ? ST_WRITE : ST_RD_ISSUE;
      ST_WRITE:    state_nxt = ST_IDLE;
      ST_RD_ISSUE: state_nxt = ST_RD_HOLD;
      ST_RD_HOLD:  state_nxt = ST_RD_DONE;
      ST_RD_DONE:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Strobes decode from the state register only, so req never reaches the pins
  always_comb begin
    ram_select = 1'b0;
    ram_write  = 1'b0;
    ram_out    = 1'b0;
    drive      = 1'b0;
    done_any   = 1'b0;
    unique case (state)
      ST_WRITE: begin
        ram_select = 1'b1;
        ram_write  = 1'b1;
        drive      = 1'b1;
        done_any   = 1'b1;
      end
      ST_RD_ISSUE, ST_RD_HOLD: begin
        ram_select = 1'b1;
        ram_out    = 1'b1;
      end
      ST_RD_DONE: done_any = 1'b1;
      default: ;
    endcase
  end

  assign a_done      = done_any & (owner == OWN_A);
  assign b_done      = done_any & (owner == OWN_B);
  assign ram_address = op.addr;
  assign ram_data    = drive ? op.wdata : {dataWidth{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and a
// transaction-level reference model (grant order, latency, memory contents).
module tb_ram_arbiter;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       a_req, a_write, b_req, b_write;
  logic [7:0] a_address, a_wdata, b_address, b_wdata;
  logic       a_done, b_done;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_select, ram_write, ram_out;
  logic [7:0] ram_address;
  wire  [7:0] ram_data;

  always #5 clock = ~clock;

  ram_arbiter dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_write(a_write), .a_address(a_address), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_write(b_write), .b_address(b_address), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata),
    .ram_select(ram_select), .ram_write(ram_write), .ram_out(ram_out),
    .ram_address(ram_address), .ram_data(ram_data)
  );

  // Behavioural single-port RAM: drives the bus only when select&out&~write
  logic [7:0] ram_mem [256];
  logic [7:0] ram_q;
  wire        ram_drv = ram_select & ram_out & ~ram_write;
  assign ram_data = ram_drv ? ram_q : 8'bzzzzzzzz;

  always @(posedge clock) begin
    if (ram_select & ram_write) ram_mem[ram_address] <= ram_data;
    if (ram_drv) ram_q <= ram_mem[ram_address];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         n = 0;
  int         idle_edge = 0;
  int         exp_done_n = -1;
  int         g_n = 0;
  bit         g_valid = 0;
  bit         g_rd, g_own;
  logic [7:0] g_addr, g_wd, exp_rdv;
  bit         mptr = 0;
  logic [7:0] mm [256];
  logic [7:0] ma_rdata = 8'h00, mb_rdata = 8'h00;
  int         a_left = 0, b_left = 0;
  int         a_start_n = 0, a_done_n = 0;
  logic [7:0] zz = 8'bzzzzzzzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_op_a();
    a_write = 1'($urandom_range(0, 1));
    a_address = 8'h20 + 8'($urandom_range(0, 3));
    a_wdata = 8'($urandom);
  endtask

  task automatic new_op_b();
    b_write = 1'($urandom_range(0, 1));
    b_address = 8'h20 + 8'($urandom_range(0, 3));
    b_wdata = 8'($urandom);
  endtask

  // Decide what the controller does at edge n from the current inputs
  task automatic model_edge();
    bit w;
    if (reset) begin
      g_valid = 0; exp_done_n = -1; idle_edge = n + 1; mptr = 0;
      ma_rdata = 8'h00; mb_rdata = 8'h00;
    end else if (n >= idle_edge && (a_req || b_req)) begin
      g_own = (a_req && b_req) ? (RR ? mptr : 1'b0) : b_req;
      if (RR) mptr = ~g_own;
      w      = g_own ? b_write : a_write;
      g_addr = g_own ? b_address : a_address;
      g_wd   = g_own ? b_wdata : a_wdata;
      g_valid = 1; g_n = n; g_rd = !w;
      exp_done_n = n + (w ? 1 : 3);
      idle_edge  = n + (w ? 2 : 4);
      if (w) mm[g_addr] = g_wd;
      else   exp_rdv = mm[g_addr];
    end
  endtask

  task automatic cycle();
    int k; bit esel, ewr, eout, dn;
    model_edge();
    @(negedge clock);
    n++;
    k    = n - g_n;
    esel = g_valid && (g_rd ? (k == 1 || k == 2) : (k == 1));
    ewr  = g_valid && !g_rd && k == 1;
    eout = g_valid && g_rd && (k == 1 || k == 2);
    dn   = (n == exp_done_n);
    if (dn && g_rd) begin
      if (g_own) mb_rdata = exp_rdv;
      else       ma_rdata = exp_rdv;
    end
    check("ram_select", ram_select, esel);
    check("ram_write", ram_write, ewr);
    check("ram_out", ram_out, eout);
    if (esel) check("ram_address", ram_address, g_addr);
    check("a_done", a_done, dn && !g_own);
    check("b_done", b_done, dn && g_own);
    check("a_rdata", a_rdata, ma_rdata);
    check("b_rdata", b_rdata, mb_rdata);
    check("bus_contention", ram_drv & ram_select & ram_write, 1'b0);
    if (ewr) check("bus_wdata", ram_data, g_wd);
    else if (!eout) check("bus_z", ram_data, zz);
    if (dn && !g_own) begin
      a_done_n = n; a_left--;
      if (a_left > 0) new_op_a(); else a_req = 0;
    end
    if (dn && g_own) begin
      b_left--;
      if (b_left > 0) new_op_b(); else b_req = 0;
    end
  endtask

  task automatic run_ops();
    int guard = 0;
    while ((a_left > 0 || b_left > 0 || n < idle_edge - 1) && guard < 400) begin
      cycle();
      guard++;
    end
    if (guard >= 400) begin
      checks++; errors++;
      $error("FAIL run_timeout: observed %0d cycles, expected < 400", guard);
    end
  endtask

  task automatic set_a(input bit w, input logic [7:0] ad, input logic [7:0] d);
    a_write = w; a_address = ad; a_wdata = d; a_req = 1; a_left = 1; a_start_n = n;
  endtask

  task automatic set_b(input bit w, input logic [7:0] ad, input logic [7:0] d);
    b_write = w; b_address = ad; b_wdata = d; b_req = 1; b_left = 1;
  endtask

  initial begin
    reset = 1; a_req = 1; a_write = 0; a_address = 8'h00; a_wdata = 8'h00;
    b_req = 0; b_write = 0; b_address = 8'h00; b_wdata = 8'h00;

    // Reset held three cycles with a pending A request
    repeat (3) begin
      cycle();
      check("rst_address", ram_address, 8'h00);
      check("rst_a_rdata", a_rdata, 8'h00);
    end
    reset = 0; a_req = 0;
    cycle();

    // Reset in RD_HOLD aborts the read: no done, rdata not captured
    set_a(1, 8'h40, 8'h77); run_ops(); cycle();
    set_a(0, 8'h40, 8'h00);
    cycle(); cycle();
    check("rdhold_ram_out", ram_out, 1'b1);
    reset = 1; a_req = 0; a_left = 0;
    cycle();
    check("abort_no_done", a_done, 1'b0);
    check("abort_rdata", a_rdata, 8'h00);
    check("abort_select", ram_select, 1'b0);
    reset = 0;
    cycle();

    // A writes 0x5A to 0x10 then reads it back
    set_a(1, 8'h10, 8'h5A); run_ops();
    check("wr_latency", a_done_n - a_start_n, 1);
    cycle();
    set_a(0, 8'h10, 8'h00); run_ops();
    check("rd_latency", a_done_n - a_start_n, 3);
    check("rd_5a", a_rdata, 8'h5A);

    // Prefill the addresses used by the random phases
    for (int i = 0; i < 4; i++) begin
      set_a(1, 8'h20 + 8'(i), 8'($urandom)); run_ops();
    end
    set_a(1, 8'h3F, 8'h11); run_ops();

    // B writes 0xC3 to 0x3F while A reads 0x3F: A's result follows grant order
    set_a(0, 8'h3F, 8'h00); set_b(1, 8'h3F, 8'hC3); run_ops();
    set_b(0, 8'h3F, 8'h00); run_ops();
    check("b_rd_c3", b_rdata, 8'hC3);

    // Continuous contention with random reads and writes
    a_left = 8; new_op_a(); a_req = 1;
    b_left = 8; new_op_b(); b_req = 1;
    run_ops();

    // Random uncontended traffic from each side
    b_left = 6; new_op_b(); b_req = 1; run_ops();
    a_left = 6; new_op_a(); a_req = 1; run_ops();
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
